// File: rtl/i2c_reg_sequencer.sv
// rtl/i2c_reg_sequencer.sv - WISHBONE sequencer for single-register I2C transfers through an I2C master core
module i2c_reg_sequencer #(
    parameter logic [15:0] PRESCALE   = 16'd99,
    parameter logic [19:0] POLL_LIMIT = 20'd100000
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rnw,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] rsp_status,
    output logic [2:0] m_adr_o,
    output logic [7:0] m_dat_o,
    input  logic [7:0] m_dat_i,
    output logic       m_we_o,
    output logic       m_stb_o,
    output logic       m_cyc_o,
    input  logic       m_ack_i
);

    localparam logic [2:0] ADR_PRERLO = 3'd0;
    localparam logic [2:0] ADR_PRERHI = 3'd1;
    localparam logic [2:0] ADR_CTR    = 3'd2;
    localparam logic [2:0] ADR_TXR    = 3'd3;
    localparam logic [2:0] ADR_CR     = 3'd4;

    localparam logic [7:0] CTR_EN        = 8'h80;
    localparam logic [7:0] CR_STA_WR     = 8'h90;
    localparam logic [7:0] CR_WR         = 8'h10;
    localparam logic [7:0] CR_STO_WR     = 8'h50;
    localparam logic [7:0] CR_RD_ACK_STO = 8'h68;
    localparam logic [7:0] CR_STO        = 8'h40;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_NACK    = 2'd1;
    localparam logic [1:0] ST_ARBLOST = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    // S_GAP is the mandatory idle cycle that launches the access selected by op_q.
    typedef enum logic [1:0] {S_GAP, S_ACC, S_IDLE} state_t;
    typedef enum logic [3:0] {
        OP_PRERLO, OP_PRERHI, OP_CTR, OP_TXR, OP_CR,
        OP_POLL, OP_RXR, OP_STOP, OP_STOP_POLL
    } op_t;

    state_t      state_q;
    op_t         op_q;
    logic [1:0]  bidx_q;     // byte step: 0 dev, 1 reg, 2 data / repeated-start dev, 3 read byte
    logic        rnw_q;
    logic [6:0]  dev_q;
    logic [7:0]  reg_q;
    logic [7:0]  wdata_q;
    logic [1:0]  err_q;
    logic [19:0] poll_cnt_q;

    logic        req_ready_q, rsp_valid_q;
    logic [7:0]  rsp_rdata_q;
    logic [1:0]  rsp_status_q;
    logic [2:0]  m_adr_q;
    logic [7:0]  m_dat_q;
    logic        m_we_q, m_stb_q, m_cyc_q;

    logic [7:0]  tx_byte_d, cr_byte_d;
    logic [2:0]  acc_adr_d;
    logic [7:0]  acc_dat_d;
    logic        acc_we_d;
    logic [19:0] poll_cnt_d;
    logic        poll_expired_d;
    logic        fin_d;
    logic [1:0]  fin_status_d;
    logic [7:0]  fin_rdata_d;
    logic        sr_tip, sr_al, sr_rxack;

    assign sr_tip   = m_dat_i[1];
    assign sr_al    = m_dat_i[5];
    assign sr_rxack = m_dat_i[7];

    assign poll_cnt_d     = poll_cnt_q + 20'd1;
    assign poll_expired_d = (poll_cnt_d >= POLL_LIMIT);

    // Byte and command for the current byte step, then the bus values for the pending access.
    always_comb begin
        tx_byte_d = 8'h00;
        cr_byte_d = CR_RD_ACK_STO;
        case (bidx_q)
            2'd0: begin tx_byte_d = {dev_q, 1'b0}; cr_byte_d = CR_STA_WR; end
            2'd1: begin tx_byte_d = reg_q;         cr_byte_d = CR_WR;     end
            2'd2: begin
                tx_byte_d = rnw_q ? {dev_q, 1'b1} : wdata_q;
                cr_byte_d = rnw_q ? CR_STA_WR : CR_STO_WR;
            end
            default: begin tx_byte_d = 8'h00; cr_byte_d = CR_RD_ACK_STO; end
        endcase

        acc_adr_d = ADR_CR;
        acc_dat_d = 8'h00;
        acc_we_d  = 1'b0;
        case (op_q)
            OP_PRERLO: begin acc_adr_d = ADR_PRERLO; acc_dat_d = PRESCALE[7:0];  acc_we_d = 1'b1; end
            OP_PRERHI: begin acc_adr_d = ADR_PRERHI; acc_dat_d = PRESCALE[15:8]; acc_we_d = 1'b1; end
            OP_CTR:    begin acc_adr_d = ADR_CTR;    acc_dat_d = CTR_EN;         acc_we_d = 1'b1; end
            OP_TXR:    begin acc_adr_d = ADR_TXR;    acc_dat_d = tx_byte_d;      acc_we_d = 1'b1; end
            OP_CR:     begin acc_adr_d = ADR_CR;     acc_dat_d = cr_byte_d;      acc_we_d = 1'b1; end
            OP_STOP:   begin acc_adr_d = ADR_CR;     acc_dat_d = CR_STO;         acc_we_d = 1'b1; end
            OP_RXR:    begin acc_adr_d = ADR_TXR;    acc_dat_d = 8'h00;          acc_we_d = 1'b0; end
            default:   begin acc_adr_d = ADR_CR;     acc_dat_d = 8'h00;          acc_we_d = 1'b0; end
        endcase
    end

    // Decide on the ack cycle whether this access completes the command, so rsp_valid lands one cycle later.
    always_comb begin
        fin_d        = 1'b0;
        fin_status_d = ST_OK;
        fin_rdata_d  = 8'h00;
        if (state_q == S_ACC && m_ack_i) begin
            case (op_q)
                OP_POLL: begin
                    if (!sr_tip) begin
                        if (sr_al) begin
                            fin_d        = 1'b1;
                            fin_status_d = ST_ARBLOST;
                        end else if (!(sr_rxack && bidx_q != 2'd3) && bidx_q == 2'd2 && !rnw_q) begin
                            fin_d = 1'b1;
                        end
                    end
                end
                OP_RXR: begin
                    fin_d       = 1'b1;
                    fin_rdata_d = m_dat_i;
                end
                OP_STOP: begin
                    if (err_q == ST_TIMEOUT) begin
                        fin_d        = 1'b1;
                        fin_status_d = ST_TIMEOUT;
                    end
                end
                OP_STOP_POLL: begin
                    if (!sr_tip || poll_expired_d) begin
                        fin_d        = 1'b1;
                        fin_status_d = err_q;
                    end
                end
                default: fin_d = 1'b0;
            endcase
        end
    end

    // Main sequencer: init, command acceptance, bus access handshake and byte-step decisions.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q      <= S_GAP;
            op_q         <= OP_PRERLO;
            bidx_q       <= 2'd0;
            rnw_q        <= 1'b0;
            dev_q        <= 7'd0;
            reg_q        <= 8'd0;
            wdata_q      <= 8'd0;
            err_q        <= ST_OK;
            poll_cnt_q   <= 20'd0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 8'd0;
            rsp_status_q <= ST_OK;
            m_adr_q      <= 3'd0;
            m_dat_q      <= 8'd0;
            m_we_q       <= 1'b0;
            m_stb_q      <= 1'b0;
            m_cyc_q      <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_GAP: begin
                    m_adr_q <= acc_adr_d;
                    m_dat_q <= acc_dat_d;
                    m_we_q  <= acc_we_d;
                    m_cyc_q <= 1'b1;
                    m_stb_q <= 1'b1;
                    state_q <= S_ACC;
                end
                S_IDLE: begin
                    if (req_valid) begin
                        rnw_q       <= req_rnw;
                        dev_q       <= req_dev;
                        reg_q       <= req_reg;
                        wdata_q     <= req_wdata;
                        bidx_q      <= 2'd0;
                        err_q       <= ST_OK;
                        op_q        <= OP_TXR;
                        req_ready_q <= 1'b0;
                        m_adr_q     <= ADR_TXR;
                        m_dat_q     <= {req_dev, 1'b0};
                        m_we_q      <= 1'b1;
                        m_cyc_q     <= 1'b1;
                        m_stb_q     <= 1'b1;
                        state_q     <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (m_ack_i) begin
                        m_cyc_q <= 1'b0;
                        m_stb_q <= 1'b0;
                        m_we_q  <= 1'b0;
                        m_adr_q <= 3'd0;
                        m_dat_q <= 8'd0;
                        state_q <= S_GAP;
                        case (op_q)
                            OP_PRERLO: op_q <= OP_PRERHI;
                            OP_PRERHI: op_q <= OP_CTR;
                            OP_CTR: begin
                                state_q     <= S_IDLE;
                                req_ready_q <= 1'b1;
                            end
                            OP_TXR: op_q <= OP_CR;
                            OP_CR: begin
                                op_q       <= OP_POLL;
                                poll_cnt_q <= 20'd0;
                            end
                            OP_POLL: begin
                                if (sr_tip) begin
                                    if (poll_expired_d) begin
                                        op_q  <= OP_STOP;
                                        err_q <= ST_TIMEOUT;
                                    end else begin
                                        poll_cnt_q <= poll_cnt_d;
                                    end
                                end else if (sr_rxack && bidx_q != 2'd3) begin
                                    op_q  <= OP_STOP;
                                    err_q <= ST_NACK;
                                end else if (bidx_q == 2'd3) begin
                                    op_q <= OP_RXR;
                                end else if (bidx_q == 2'd2) begin
                                    bidx_q <= 2'd3;
                                    op_q   <= OP_CR;
                                end else begin
                                    bidx_q <= bidx_q + 2'd1;
                                    op_q   <= OP_TXR;
                                end
                            end
                            OP_STOP: begin
                                op_q       <= OP_STOP_POLL;
                                poll_cnt_q <= 20'd0;
                            end
                            OP_STOP_POLL: poll_cnt_q <= poll_cnt_d;
                            default: op_q <= op_q;
                        endcase
                        if (fin_d) begin
                            state_q      <= S_IDLE;
                            req_ready_q  <= 1'b1;
                            rsp_valid_q  <= 1'b1;
                            rsp_status_q <= fin_status_d;
                            rsp_rdata_q  <= fin_rdata_d;
                        end
                    end
                end
                default: state_q <= S_GAP;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_status = rsp_status_q;
    assign m_adr_o    = m_adr_q;
    assign m_dat_o    = m_dat_q;
    assign m_we_o     = m_we_q;
    assign m_stb_o    = m_stb_q;
    assign m_cyc_o    = m_cyc_q;

endmodule
